// File: rtl/picture_ycbcr444_rgb888_if.sv
// rtl/picture_ycbcr444_rgb888_if.sv - Pixel-stream bundle for the YCbCr444-to-RGB888 converter
interface picture_ycbcr444_rgb888_if;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] per_img_Y;
    logic [7:0] per_img_Cb;
    logic [7:0] per_img_Cr;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_red;
    logic [7:0] post_img_green;
    logic [7:0] post_img_blue;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
        output per_img_Y, per_img_Cb, per_img_Cr,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_img_red, post_img_green, post_img_blue
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        input  per_img_Y, per_img_Cb, per_img_Cr,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_img_red, post_img_green, post_img_blue
    );
endinterface

// File: rtl/picture_ycbcr444_rgb888.sv
// rtl/picture_ycbcr444_rgb888.sv - 3-stage free-running YCbCr444 to RGB888 converter
// Optional macro YCBCR_STUDIO_RANGE_EN selects BT.601 studio-range coefficients.
module picture_ycbcr444_rgb888 (
    input  logic                              clk,
    input  logic                              rst_n,
    picture_ycbcr444_rgb888_if.slave          bus
);

    logic signed [8:0]  cb_d, cr_d;
    logic signed [18:0] y_s_d, pr_d, pgb_d, pgr_d, pb_d;
    logic signed [18:0] y_s_q, pr_q, pgb_q, pgr_q, pb_q;
    logic signed [19:0] r_s_d, g_s_d, b_s_d;
    logic signed [19:0] r_s_q, g_s_q, b_s_q;
    logic [7:0]         red_d, green_d, blue_d;
    logic [7:0]         red_q, green_q, blue_q;
    logic [2:0]         vsync_q, href_q, clken_q;

    // Scale by 2^-8 then saturate into the 8-bit unsigned range.
    function automatic logic [7:0] clamp8(input logic signed [19:0] s);
        logic signed [19:0] t;
        t = s >>> 8;
        if (t < 20'sd0)
            clamp8 = 8'd0;
        else if (t > 20'sd255)
            clamp8 = 8'd255;
        else
            clamp8 = t[7:0];
    endfunction

    always_comb begin
        cb_d = $signed({1'b0, bus.per_img_Cb}) - 9'sd128;
        cr_d = $signed({1'b0, bus.per_img_Cr}) - 9'sd128;
`ifdef YCBCR_STUDIO_RANGE_EN
        y_s_d = 19'($signed({1'b0, bus.per_img_Y}) - 9'sd16) * 19'sd298 + 19'sd128;
        pr_d  = 19'(cr_d) * 19'sd409;
        pgb_d = 19'(cb_d) * 19'sd100;
        pgr_d = 19'(cr_d) * 19'sd208;
        pb_d  = 19'(cb_d) * 19'sd516;
`else
        // Y*256 + 128 is just Y with the rounding half appended.
        y_s_d = {3'b000, bus.per_img_Y, 8'h80};
        pr_d  = 19'(cr_d) * 19'sd359;
        pgb_d = 19'(cb_d) * 19'sd88;
        pgr_d = 19'(cr_d) * 19'sd183;
        pb_d  = 19'(cb_d) * 19'sd454;
`endif
        r_s_d   = 20'(y_s_q) + 20'(pr_q);
        g_s_d   = 20'(y_s_q) - 20'(pgb_q) - 20'(pgr_q);
        b_s_d   = 20'(y_s_q) + 20'(pb_q);
        red_d   = clamp8(r_s_q);
        green_d = clamp8(g_s_q);
        blue_d  = clamp8(b_s_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s_q   <= '0;
            pr_q    <= '0;
            pgb_q   <= '0;
            pgr_q   <= '0;
            pb_q    <= '0;
            r_s_q   <= '0;
            g_s_q   <= '0;
            b_s_q   <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            vsync_q <= '0;
            href_q  <= '0;
            clken_q <= '0;
        end else begin
            y_s_q   <= y_s_d;
            pr_q    <= pr_d;
            pgb_q   <= pgb_d;
            pgr_q   <= pgr_d;
            pb_q    <= pb_d;
            r_s_q   <= r_s_d;
            g_s_q   <= g_s_d;
            b_s_q   <= b_s_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            vsync_q <= {vsync_q[1:0], bus.per_frame_vsync};
            href_q  <= {href_q[1:0],  bus.per_frame_href};
            clken_q <= {clken_q[1:0], bus.per_frame_clken};
        end
    end

    assign bus.post_frame_vsync = vsync_q[2];
    assign bus.post_frame_href  = href_q[2];
    assign bus.post_frame_clken = clken_q[2];
    // Blank the colour outputs outside the active line.
    assign bus.post_img_red     = href_q[2] ? red_q   : 8'd0;
    assign bus.post_img_green   = href_q[2] ? green_q : 8'd0;
    assign bus.post_img_blue    = href_q[2] ? blue_q  : 8'd0;

endmodule

// File: tb/tb_picture_ycbcr444_rgb888.sv
// tb/tb_picture_ycbcr444_rgb888.sv - Directed-vector bench for picture_ycbcr444_rgb888
module tb_picture_ycbcr444_rgb888;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    picture_ycbcr444_rgb888_if bus ();

    picture_ycbcr444_rgb888 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                         input logic h, input logic v, input logic k);
        bus.per_img_Y       = y;
        bus.per_img_Cb      = cb;
        bus.per_img_Cr      = cr;
        bus.per_frame_href  = h;
        bus.per_frame_vsync = v;
        bus.per_frame_clken = k;
    endtask

    localparam int NV = 6;
    localparam int NC = 24;

    logic [7:0] vy[NV], vcb[NV], vcr[NV], vr[NV], vg[NV], vb[NV];
    logic [7:0] rst_y, rst_cb, rst_cr, rst_r, rst_g, rst_b;

    logic [7:0] s_y[NC], s_cb[NC], s_cr[NC], e_r[NC], e_g[NC], e_b[NC];
    logic       s_h[NC], s_v[NC], s_k[NC];

    task automatic set_vec(input int i, input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vy[i] = y; vcb[i] = cb; vcr[i] = cr; vr[i] = r; vg[i] = g; vb[i] = b;
    endtask

    initial begin
`ifdef YCBCR_STUDIO_RANGE_EN
        set_vec(0, 8'd126, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
        set_vec(1, 8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
        set_vec(2, 8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
        set_vec(3, 8'd126, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
        set_vec(4, 8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
        set_vec(5, 8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
        rst_y = 8'd255; rst_cb = 8'd128; rst_cr = 8'd255;
        rst_r = 8'd255; rst_g  = 8'd175; rst_b  = 8'd255;
`else
        set_vec(0, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
        set_vec(1, 8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
        set_vec(2, 8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
        set_vec(3, 8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0);
        set_vec(4, 8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255);
        set_vec(5, 8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0);
        rst_y = 8'd255; rst_cb = 8'd128; rst_cr = 8'd255;
        rst_r = 8'd255; rst_g  = 8'd164; rst_b  = 8'd255;
`endif
        // 1-clk vsync, a 10-clk href window, a 1-clk href pulse, clken toggling.
        for (int c = 0; c < NC; c++) begin
            s_y[c]  = vy[c % NV];
            s_cb[c] = vcb[c % NV];
            s_cr[c] = vcr[c % NV];
            s_v[c]  = (c == 0);
            s_h[c]  = ((c >= 2) && (c <= 11)) || (c == 15);
            s_k[c]  = c[0];
            e_r[c]  = s_h[c] ? vr[c % NV] : 8'd0;
            e_g[c]  = s_h[c] ? vg[c % NV] : 8'd0;
            e_b[c]  = s_h[c] ? vb[c % NV] : 8'd0;
        end

        rst_n = 1'b0;
        drive(8'd255, 8'd128, 8'd255, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check_val("reset_red",   32'(bus.post_img_red),     32'd0);
        check_val("reset_green", 32'(bus.post_img_green),   32'd0);
        check_val("reset_blue",  32'(bus.post_img_blue),    32'd0);
        check_val("reset_vsync", 32'(bus.post_frame_vsync), 32'd0);
        check_val("reset_href",  32'(bus.post_frame_href),  32'd0);
        check_val("reset_clken", 32'(bus.post_frame_clken), 32'd0);
        rst_n = 1'b1;
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        for (int c = 0; c < NC + 3; c++) begin
            if (c >= 3) begin
                check_val($sformatf("vsync[%0d]", c - 3), 32'(bus.post_frame_vsync), 32'(s_v[c - 3]));
                check_val($sformatf("href[%0d]",  c - 3), 32'(bus.post_frame_href),  32'(s_h[c - 3]));
                check_val($sformatf("clken[%0d]", c - 3), 32'(bus.post_frame_clken), 32'(s_k[c - 3]));
                check_val($sformatf("red[%0d]",   c - 3), 32'(bus.post_img_red),     32'(e_r[c - 3]));
                check_val($sformatf("green[%0d]", c - 3), 32'(bus.post_img_green),   32'(e_g[c - 3]));
                check_val($sformatf("blue[%0d]",  c - 3), 32'(bus.post_img_blue),    32'(e_b[c - 3]));
            end
            if (c < NC)
                drive(s_y[c], s_cb[c], s_cr[c], s_h[c], s_v[c], s_k[c]);
            else
                drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Mid-line asynchronous reset.
        drive(rst_y, rst_cb, rst_cr, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_val("pre_rst_red",   32'(bus.post_img_red),    32'(rst_r));
        check_val("pre_rst_green", 32'(bus.post_img_green),  32'(rst_g));
        check_val("pre_rst_blue",  32'(bus.post_img_blue),   32'(rst_b));
        check_val("pre_rst_href",  32'(bus.post_frame_href), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_red",   32'(bus.post_img_red),     32'd0);
        check_val("async_rst_green", 32'(bus.post_img_green),   32'd0);
        check_val("async_rst_blue",  32'(bus.post_img_blue),    32'd0);
        check_val("async_rst_vsync", 32'(bus.post_frame_vsync), 32'd0);
        check_val("async_rst_href",  32'(bus.post_frame_href),  32'd0);
        check_val("async_rst_clken", 32'(bus.post_frame_clken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst1_href", 32'(bus.post_frame_href), 32'd0);
        check_val("post_rst1_red",  32'(bus.post_img_red),    32'd0);
        @(negedge clk);
        check_val("post_rst2_href", 32'(bus.post_frame_href), 32'd0);
        check_val("post_rst2_red",  32'(bus.post_img_red),    32'd0);
        @(negedge clk);
        check_val("post_rst3_href",  32'(bus.post_frame_href),  32'd1);
        check_val("post_rst3_vsync", 32'(bus.post_frame_vsync), 32'd1);
        check_val("post_rst3_red",   32'(bus.post_img_red),     32'(rst_r));
        check_val("post_rst3_green", 32'(bus.post_img_green),   32'(rst_g));
        check_val("post_rst3_blue",  32'(bus.post_img_blue),    32'(rst_b));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/picture_ycbcr444_rgb888.md
Name: picture_ycbcr444_rgb888

Overview:
Pipelined YCbCr444-to-RGB888 colour-space converter. It is the inverse of the camera-side RGB-to-YCbCr stage. It sits after the YCbCr processing chain (filters, thresholding, overlay) and before the RGB display/VGA/HDMI output. Frame sync signals pass through with a latency that matches the data.

Parameters:
None. The fixed-point scale is 2^8, and the coefficients are decided constants listed under Behaviour.

Ports:
clk  input  1  pixel clock; all registers on rising edge
rst_n  input  1  asynchronous, active-low reset
per_frame_vsync  input  1  input frame vsync
per_frame_href  input  1  input line valid
per_frame_clken  input  1  input pixel strobe
per_img_Y  input  8  luma, unsigned
per_img_Cb  input  8  blue-difference chroma, unsigned, 128 offset
per_img_Cr  input  8  red-difference chroma, unsigned, 128 offset
post_frame_vsync  output  1  vsync delayed 3 clk
post_frame_href  output  1  href delayed 3 clk
post_frame_clken  output  1  clken delayed 3 clk
post_img_red  output  8  R, unsigned, clamped
post_img_green  output  8  G, unsigned, clamped
post_img_blue  output  8  B, unsigned, clamped

Behaviour:
- Reset: all pipeline and sync registers clear to 0 asynchronously on rst_n low. All outputs read 0 while reset is held. Asserting reset mid-frame discards in-flight pixels with no partial output.
- Pipeline is free-running: every stage loads every clk and does not depend on clken. clken is only delayed.
- Stage 1 (products), per clock:
  - Combinationally form cb_d = Cb - 128 and cr_d = Cr - 128, both 9-bit signed.
  - Register y_s = Y*256 + 128, with the +128 being the rounding constant.
  - Register pr = 359*cr_d, pgb = 88*cb_d, pgr = 183*cr_d, pb = 454*cb_d.
  - All products are 19-bit signed.
- Stage 2 (sums), registered, 20-bit signed:
  - r_s = y_s + pr
  - g_s = y_s - pgb - pgr
  - b_s = y_s + pb
- Stage 3 (scale and clamp), registered 8-bit, applied to each of r/g/b independently:
  - Arithmetic shift right by 8.
  - If the result is < 0, output 0.
  - If the result is > 255, output 255.
  - Otherwise output result[7:0].
- Latency is exactly 3 clk from input to output for data, vsync, href and clken. Each sync signal uses its own 3-bit shift register.
- Output gating: post_img_red/green/blue equal the stage-3 registers when post_frame_href = 1 and are forced to 0 when post_frame_href = 0. This gating is combinational on the delayed href.
- No overflow is possible internally. The worst-case magnitude fits within the 20-bit signed sums.
- vsync and href are not interpreted. There is no state machine beyond the pipeline, so back-to-back frames and 1-clk href pulses pass through unchanged.

Optional Feature:
Macro: YCBCR_STUDIO_RANGE_EN
- Defined: inputs are treated as BT.601 studio range (Y 16-235, C 16-240).
  - Stage 1 uses y_s = 298*(Y-16) + 128, where Y-16 is 9-bit signed.
  - Coefficients become pr = 409*cr_d, pgb = 100*cb_d, pgr = 208*cr_d, pb = 516*cb_d.
  - Sums, clamping, latency and gating are unchanged.
  - Inputs outside the studio range still clamp cleanly to 0 or 255.
- Undefined: full-range coefficients as listed under Behaviour.

Test Plan:
- Full range, Y/Cb/Cr = 128/128/128 held, href=1 -> after exactly 3 clk RGB = 128/128/128. Y=255 gives 255/255/255; Y=0 gives 0/0/0.
- Y/Cb/Cr = 76/85/255 -> RGB = 254/0/0. The G sum of 127 truncates to 0, and the B sum of 62 truncates to 0.
- Clamping: 255/128/255 -> 255/164/255 (R sum 433 clamps high). 0/0/0 -> 0/136/0 (R and B sums negative clamp low).
- Sync alignment: a 1-clk vsync pulse, a 10-clk href window and a clken toggling every clk -> each appears at the outputs shifted by exactly 3 clk. RGB is 0 in every cycle where post_frame_href=0, even with nonzero input data.
- Reset mid-line: pulse rst_n low for 1 clk with href=1 and data 255/128/255 -> outputs and sync go to 0 immediately and asynchronously. The first valid pixel reappears 3 clk after new input following reset release.
- With YCBCR_STUDIO_RANGE_EN: 235/128/128 -> 255/255/255; 16/128/128 -> 0/0/0; 126/128/128 -> 128/128/128.
